atm_cash_dispenser: RTL

Downstream stage of the ATM controller. It consumes the controller's Withdrawed_Successfully pulse and the 7-bit withdrawal amount, and plans a greedy note breakdown against per-denomination inventory counters. It then drives the note mechanism one note at a time over a req/ack handshake. It reports completion, failure (insufficient notes or mechanism jam) and low-cash status back to the controller and bench.

---
 rtl/atm_pkg.sv | 38 +++
 rtl/atm_note_handshake.sv | 43 ++++
 rtl/atm_cash_dispenser.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/atm_pkg.sv
// Shared types and constants for the ATM cash dispenser.
// Denomination table, FSM states and a constant-divisor helper.
package atm_pkg;

  localparam int NUM_DENOM = 5;

  typedef logic [2:0] denom_idx_t;

  // Index 0 is the largest note; greedy planning walks upward.
  localparam logic [NUM_DENOM-1:0][6:0] DENOM =
    {7'd1, 7'd5, 7'd10, 7'd20, 7'd50};

  typedef enum logic [2:0] {
    IDLE,
    PLAN,
    CHECK,
    DISPENSE,
    WAIT_ACK,
    DONE,
    FAIL
  } disp_state_t;

  function automatic logic [6:0] denom_div(
    input logic [6:0] v,
    input denom_idx_t i
  );
    logic [6:0] q;
    unique case (i)
      3'd0:    q = v / 7'd50;
      3'd1:    q = v / 7'd20;
      3'd2:    q = v / 7'd10;
      3'd3:    q = v / 7'd5;
      default: q = v;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/atm_note_handshake.sv
// One-note req/ack handshake toward the note mechanism.
// Holds req and denom stable until ack, flags a jam on timeout.
module atm_note_handshake
  import atm_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  denom_idx_t denom,
  input  logic       ack,
  output logic       req,
  output denom_idx_t note_denom,
  output logic       acked,
  output logic       timeout
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  logic [TW-1:0] cnt;

  // An ack in the last allowed cycle still wins over the timeout.
  assign acked   = req & ack;
  assign timeout = req & ~ack & (cnt == TW'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      req        <= 1'b0;
      note_denom <= '0;
      cnt        <= '0;
    end else if (start) begin
      req        <= 1'b1;
      note_denom <= denom;
      cnt        <= '0;
    end else if (acked || timeout) begin
      req <= 1'b0;
    end else if (req) begin
      cnt <= cnt + TW'(1);
    end
  end

endmodule

// File: rtl/atm_cash_dispenser.sv
// Greedy note planner and inventory keeper for the ATM.
// Plans one denomination per cycle, then ejects notes one by one.
module atm_cash_dispenser
  import atm_pkg::*;
#(
  parameter int INIT_NOTES  = 4,
  parameter int CNT_W       = 8,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       withdraw_valid,
  input  logic [6:0] withdraw_amount,
  input  logic       refill,
  input  logic       note_ack,
  output logic       note_req,
  output logic [2:0] note_denom,
  output logic       busy,
  output logic       dispense_done,
  output logic       dispense_fail,
  output logic       jam,
  output logic [6:0] dispensed_total,
  output logic       inv_low
);

  localparam int PW = CNT_W + 7;
  localparam logic [CNT_W-1:0] INIT = CNT_W'(INIT_NOTES);

  disp_state_t state, state_n;

  logic [CNT_W-1:0] inv  [NUM_DENOM];
  logic [CNT_W-1:0] plan [NUM_DENOM];
  logic [6:0]       rem;
  denom_idx_t       pidx;

  logic       start, acked, timeout, have_note;
  denom_idx_t sel_idx;

  logic [PW-1:0] quot_w, inv_w, take_w, sub_w;
  logic [6:0]    rem_next;

  // take = min(rem / denom, inv) for the denomination being planned
  always_comb begin
    quot_w   = PW'(denom_div(rem, pidx));
    inv_w    = PW'(inv[pidx]);
    take_w   = (quot_w < inv_w) ? quot_w : inv_w;
    sub_w    = take_w * PW'(DENOM[pidx]);
    rem_next = rem - sub_w[6:0];
  end

  always_comb begin
    have_note = 1'b0;
    sel_idx   = '0;
    for (int i = NUM_DENOM - 1; i >= 0; i--) begin
      if (plan[i] != '0) begin
        have_note = 1'b1;
        sel_idx   = denom_idx_t'(i);
      end
    end
  end

  always_comb begin
    inv_low = 1'b0;
    for (int i = 0; i < NUM_DENOM; i++) begin
      if (inv[i] == '0) inv_low = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    start   = 1'b0;
    unique case (state)
      IDLE: begin
        if (withdraw_valid)
          state_n = (jam && !refill) ? FAIL : PLAN;
      end
      PLAN: begin
        if (pidx == denom_idx_t'(NUM_DENOM - 1))
          state_n = CHECK;
      end
      CHECK:
        state_n = (rem == '0) ? DISPENSE : FAIL;
      DISPENSE: begin
        if (have_note) begin
          start   = 1'b1;
          state_n = WAIT_ACK;
        end else begin
          state_n = DONE;
        end
      end
      WAIT_ACK: begin
        if (acked)        state_n = DISPENSE;
        else if (timeout) state_n = FAIL;
      end
      DONE:    state_n = IDLE;
      FAIL:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem             <= '0;
      pidx            <= '0;
      jam             <= 1'b0;
      dispensed_total <= '0;
      for (int i = 0; i < NUM_DENOM; i++) begin
        inv[i]  <= INIT;
        plan[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (refill) begin
            jam <= 1'b0;
            for (int i = 0; i < NUM_DENOM; i++) inv[i] <= INIT;
          end
          if (withdraw_valid && (!jam || refill)) begin
            rem             <= withdraw_amount;
            pidx            <= '0;
            dispensed_total <= '0;
            for (int i = 0; i < NUM_DENOM; i++) plan[i] <= '0;
          end
        end
        PLAN: begin
          plan[pidx] <= take_w[CNT_W-1:0];
          rem        <= rem_next;
          pidx       <= pidx + 3'd1;
        end
        WAIT_ACK: begin
          if (acked) begin
            inv[note_denom]  <= inv[note_denom] - CNT_W'(1);
            plan[note_denom] <= plan[note_denom] - CNT_W'(1);
            dispensed_total  <= dispensed_total + DENOM[note_denom];
          end else if (timeout) begin
            jam <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy          = state inside {PLAN, CHECK, DISPENSE, WAIT_ACK};
  assign dispense_done = (state == DONE);
  assign dispense_fail = (state == FAIL);

  atm_note_handshake #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_hs (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .denom      (sel_idx),
    .ack        (note_ack),
    .req        (note_req),
    .note_denom (note_denom),
    .acked      (acked),
    .timeout    (timeout)
  );

endmodule
